imem_server: RTL and testbench

Instruction-memory responder that serves the CPU's fetch path over a valid/ready request/response handshake, replacing the zero-latency combinational instruction read. It holds a word-addressed program store, returns one 32-bit instruction per accepted fetch after a programmable latency, flags bad addresses, and exposes a side port for loading programs before or during execution. It sits between the fetch stage (initiator) and the program image (testbench or boot loader).

---
 rtl/imem_server.sv | 127 ++++++++++++
 tb/tb_imem_server.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_server.sv
// -----------------------------------------------------------------------------
// imem_server
//   Instruction-memory responder for the CPU fetch path. Holds a word-addressed
//   program store, accepts one fetch at a time over a valid/ready handshake and
//   returns the instruction after LATENCY cycles. Misaligned or out-of-range
//   fetches return a NOP with the error flag set. A side load port writes the
//   store at any time outside reset. The store itself is never cleared.
//
// Ports
//   w_clk        in   clock, rising-edge
//   w_rst        in   asynchronous active-high reset (control/output regs only)
//   w_req_valid  in   fetch request present
//   w_req_ready  out  request can be accepted (IDLE and no load this cycle)
//   w_req_addr   in   32-bit byte address of the instruction
//   w_rsp_valid  out  response word valid
//   w_rsp_ready  in   initiator takes the response
//   w_rsp_data   out  fetched instruction (NOP on error)
//   w_rsp_err    out  fetch address misaligned or out of range
//   w_load_en    in   write w_load_data to w_load_addr this cycle
//   w_load_addr  in   ADDR_W-bit word address for the load
//   w_load_data  in   instruction word to load
// -----------------------------------------------------------------------------
module imem_server #(
  parameter int ADDR_W  = 6,
  parameter int LATENCY = 2
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_req_valid,
  output logic              w_req_ready,
  input  logic [31:0]       w_req_addr,
  output logic              w_rsp_valid,
  input  logic              w_rsp_ready,
  output logic [31:0]       w_rsp_data,
  output logic              w_rsp_err,
  input  logic              w_load_en,
  input  logic [ADDR_W-1:0] w_load_addr,
  input  logic [31:0]       w_load_data
);

  localparam int          DEPTH    = 1 << ADDR_W;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  // WAIT lasts LATENCY-1 cycles; the counter runs down to zero inclusive.
  localparam logic [2:0]  CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_data;
  logic              r_rsp_err;
  logic [31:0]       r_mem [DEPTH];

  logic              w_accept;
  logic              w_addr_err;
  logic              w_load_we;
  logic [ADDR_W-1:0] w_word;

  // A load always has priority over a new fetch in the same cycle.
  assign w_req_ready = (r_state == IDLE) && !w_load_en;
  assign w_accept    = w_req_valid && w_req_ready;
  assign w_word      = w_req_addr[ADDR_W+1:2];
  // Addresses beyond the store are flagged rather than wrapped.
  assign w_addr_err  = (w_req_addr[1:0] != 2'b00) ||
                       (w_req_addr[31:ADDR_W+2] != '0);
  // Loads presented while reset is held are dropped.
  assign w_load_we   = w_load_en && !w_rst;

  assign w_rsp_valid = r_rsp_valid;
  assign w_rsp_data  = r_rsp_data;
  assign w_rsp_err   = r_rsp_err;

  // Program store: no reset, written from the side port in any FSM state.
  always_ff @(posedge w_clk) begin
    if (w_load_we) begin
      r_mem[w_load_addr] <= w_load_data;
    end
  end

  // Fetch FSM. Response data is captured at accept, so later loads to the
  // same word cannot disturb a response already in flight.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state     <= IDLE;
      r_cnt       <= 3'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rsp_err  <= w_addr_err;
            r_rsp_data <= w_addr_err ? NOP : r_mem[w_word];
            r_cnt      <= CNT_INIT;
            if (LATENCY == 1) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP: begin
          if (w_rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_server.sv
module tb_imem_server;

  localparam int          ADDR_W  = 6;
  localparam int          LATENCY = 2;
  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic              w_clk = 1'b0;
  logic              w_rst;
  logic              w_req_valid;
  logic              w_req_ready;
  logic [31:0]       w_req_addr;
  logic              w_rsp_valid;
  logic              w_rsp_ready;
  logic [31:0]       w_rsp_data;
  logic              w_rsp_err;
  logic              w_load_en;
  logic [ADDR_W-1:0] w_load_addr;
  logic [31:0]       w_load_data;

  imem_server #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .w_req_valid (w_req_valid),
    .w_req_ready (w_req_ready),
    .w_req_addr  (w_req_addr),
    .w_rsp_valid (w_rsp_valid),
    .w_rsp_ready (w_rsp_ready),
    .w_rsp_data  (w_rsp_data),
    .w_rsp_err   (w_rsp_err),
    .w_load_en   (w_load_en),
    .w_load_addr (w_load_addr),
    .w_load_data (w_load_data)
  );

  always #5 w_clk = ~w_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference store contents as the initiator believes them to be.
  logic [31:0]       model [DEPTH];
  logic              ld_pending;
  logic [ADDR_W-1:0] ld_addr_q;
  logic [31:0]       ld_data_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; any load presented this cycle has now landed.
  task automatic step();
    @(posedge w_clk);
    #1;
    if (ld_pending) begin
      model[ld_addr_q] = ld_data_q;
      w_load_en  = 1'b0;
      ld_pending = 1'b0;
    end
  endtask

  task automatic present_load(input logic [ADDR_W-1:0] la, input logic [31:0] ld);
    w_load_en   = 1'b1;
    w_load_addr = la;
    w_load_data = ld;
    ld_addr_q   = la;
    ld_data_q   = ld;
    ld_pending  = 1'b1;
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] la, input logic [31:0] ld);
    present_load(la, ld);
    step();
  endtask

  // One complete fetch transaction. Expected response comes from the model at
  // the accept edge; an optional load is issued the cycle after accept.
  task automatic do_fetch(input logic [31:0] addr, input int stall,
                          input bit ld, input logic [ADDR_W-1:0] la,
                          input logic [31:0] ldat);
    logic        exp_err;
    logic [31:0] exp_data;
    int          lat;
    bit          ok;
    w_req_addr  = addr;
    w_req_valid = 1'b1;
    w_rsp_ready = (stall == 0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge w_clk);
      if (w_req_ready) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      w_req_valid = 1'b0;
      return;
    end
    exp_err  = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
    exp_data = exp_err ? NOP : model[addr / 4];
    step();
    w_req_valid = 1'b0;
    if (ld) present_load(la, ldat);
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge w_clk);
      if (w_rsp_valid) begin ok = 1'b1; break; end
      step();
      lat++;
    end
    if (!ok) begin
      check("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", 32'(lat), 32'(LATENCY));
    check("ready_busy", 32'(w_req_ready), 32'd0);
    check("rsp_data", w_rsp_data, exp_data);
    check("rsp_err", 32'(w_rsp_err), 32'(exp_err));
    for (int i = 1; i < stall; i++) begin
      step();
      @(negedge w_clk);
      check("bp_valid", 32'(w_rsp_valid), 32'd1);
      check("bp_data", w_rsp_data, exp_data);
      check("bp_err", 32'(w_rsp_err), 32'(exp_err));
    end
    if (stall > 0) begin
      step();
      w_rsp_ready = 1'b1;
      @(negedge w_clk);
      check("bp_last_valid", 32'(w_rsp_valid), 32'd1);
      check("bp_last_data", w_rsp_data, exp_data);
    end
    step();
    check("rsp_done", 32'(w_rsp_valid), 32'd0);
    check("ready_idle", 32'(w_req_ready), 32'd1);
  endtask

  // Start a fetch of addr 4, then reset asynchronously after 'cyc' further
  // cycles with the response held off; no response may follow.
  task automatic reset_in_flight(input int cyc);
    w_req_addr  = 32'd4;
    w_req_valid = 1'b1;
    w_rsp_ready = 1'b0;
    @(negedge w_clk);
    check("rst_pre_ready", 32'(w_req_ready), 32'd1);
    step();
    w_req_valid = 1'b0;
    repeat (cyc) step();
    #2 w_rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(w_rsp_valid), 32'd0);
    check("rst_data", w_rsp_data, 32'd0);
    check("rst_ready", 32'(w_req_ready), 32'd1);
    // This load must be ignored: the model is deliberately not updated.
    w_load_en   = 1'b1;
    w_load_addr = 6'd1;
    w_load_data = 32'hBAD0_BAD0;
    step();
    step();
    w_load_en = 1'b0;
    #2 w_rst = 1'b0;
    w_rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("no_rsp_after_rst", 32'(w_rsp_valid), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          kind;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    ld_pending  = 1'b0;
    ld_addr_q   = '0;
    ld_data_q   = '0;
    w_rst       = 1'b1;
    w_req_valid = 1'b0;
    w_req_addr  = 32'd0;
    w_rsp_ready = 1'b1;
    w_load_en   = 1'b0;
    w_load_addr = '0;
    w_load_data = 32'd0;
    #3;
    check("reset_valid", 32'(w_rsp_valid), 32'd0);
    check("reset_data", w_rsp_data, 32'd0);
    check("reset_err", 32'(w_rsp_err), 32'd0);
    check("reset_ready", 32'(w_req_ready), 32'd1);
    w_load_en = 1'b1;
    #1;
    check("ready_vs_load", 32'(w_req_ready), 32'd0);
    w_load_en = 1'b0;
    repeat (2) @(posedge w_clk);
    #3 w_rst = 1'b0;
    step();

    // Directed program and fetches
    load_word(6'd0, 32'h0050_0093);
    load_word(6'd1, 32'h0030_0113);
    load_word(6'd2, 32'h0020_81B3);
    load_word(6'd3, 32'h0000_0013);
    do_fetch(32'd8,   0, 1'b0, '0, 32'd0);
    do_fetch(32'd6,   0, 1'b0, '0, 32'd0);
    do_fetch(32'd256, 0, 1'b0, '0, 32'd0);
    do_fetch(32'd252, 0, 1'b0, '0, 32'd0);
    do_fetch(32'd0,   5, 1'b0, '0, 32'd0);

    // Load and request in the same cycle: load wins, request waits a cycle.
    w_req_addr  = 32'd4;
    w_req_valid = 1'b1;
    present_load(6'd1, 32'hDEAD_BEEF);
    @(negedge w_clk);
    check("ready_on_load", 32'(w_req_ready), 32'd0);
    step();
    @(negedge w_clk);
    check("not_accepted_on_load", 32'(w_req_ready), 32'd1);
    do_fetch(32'd4, 0, 1'b0, '0, 32'd0);

    // Load to the fetched word while the fetch is in WAIT.
    do_fetch(32'd0, 0, 1'b1, 6'd0, 32'h1234_5678);
    do_fetch(32'd0, 0, 1'b0, '0, 32'd0);

    // Reset during WAIT, then during RESP; store must survive.
    reset_in_flight(0);
    do_fetch(32'd4, 0, 1'b0, '0, 32'd0);
    reset_in_flight(1);
    do_fetch(32'd4, 1, 1'b0, '0, 32'd0);

    // Randomized traffic against the model
    for (int i = 4; i < DEPTH; i++) load_word(6'(i), $urandom());
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 6)      a = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
      else if (kind == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else if (kind == 8) a = 32'(4 * DEPTH + 4 * $urandom_range(0, 1000));
      else                a = $urandom() | 32'h8000_0000;
      do_fetch(a, $urandom_range(0, 3), ($urandom_range(0, 2) == 0),
               6'($urandom_range(0, DEPTH - 1)), $urandom());
      if ($urandom_range(0, 3) == 0) load_word(6'($urandom_range(0, DEPTH - 1)), $urandom());
      else if ($urandom_range(0, 1) == 0) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
